vs_fp_mac_pipe: RTL and testbench

Parametrised, pipelined, streaming fixed-point multiply-accumulate engine for signed two's-complement Q-format data. It replaces the free-running single-accumulator MAC with a framed dot-product unit: `first`/`last` delimit each dot product, a valid/ready handshake runs on both sides, and rounding plus saturation are applied at the output. It sits between sample sources (FIFOs, matrix/vector readers) and the sparse-recovery arithmetic datapath.

---
 rtl/vs_fp_mac_pipe.sv | 143 ++++++++++++++
 tb/tb_vs_fp_mac_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vs_fp_mac_pipe.sv
// vs_fp_mac_pipe: framed, pipelined signed fixed-point dot-product engine.
// Pipeline: P (product) -> A (saturating accumulator) -> O (round/clamp).
// A single stall (result held and not taken) freezes all three stages.
module vs_fp_mac_pipe #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int ACC_W = 64,
  parameter int ROUND = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         first,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W:0]   RND_ADD = (ROUND != 0) ? ({{ACC_W{1'b0}}, 1'b1} << (Q-1)) : '0;
  localparam logic [N-1:0]     RES_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     RES_MIN = {1'b1, {(N-1){1'b0}}};

  // pipeline state
  logic [2*N-1:0]   p_q, p_d;
  logic             p_valid_q, p_valid_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             a_valid_q, a_valid_d, a_last_q, a_last_d, a_ovf_q, a_ovf_d;
  logic [N-1:0]     result_q, result_d;
  logic             overflow_q, overflow_d, out_valid_q, out_valid_d;

  // datapath temporaries
  logic                    stall;
  logic signed [2*N-1:0]   a_ext, b_ext, prod;
  logic [ACC_W-1:0]        acc_base, sum_sat, rnd_sat;
  logic [ACC_W:0]          p_ext, sum_wide, rnd_wide;
  logic                    sum_ovf, rnd_ovf, clamp;
  logic signed [ACC_W-1:0] shifted;
  logic [N-1:0]            res_clamped;

  // only combinational input-to-output path: out_ready -> in_ready
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // full-width signed product; operands sign-extended so the low 2N bits are exact
  assign a_ext = {{N{a[N-1]}}, a};
  assign b_ext = {{N{b[N-1]}}, b};
  assign prod  = a_ext * b_ext;

  // accumulate one guard bit wide, then saturate to the ACC_W signed range
  always_comb begin
    acc_base = p_first_q ? '0 : acc_q;
    p_ext    = {{(ACC_W+1-2*N){p_q[2*N-1]}}, p_q};
    sum_wide = {acc_base[ACC_W-1], acc_base} + p_ext;
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_sat  = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
  end

  // round (saturating), arithmetic shift by Q, then clamp into N bits
  always_comb begin
    rnd_wide    = {acc_q[ACC_W-1], acc_q} + RND_ADD;
    rnd_ovf     = rnd_wide[ACC_W] ^ rnd_wide[ACC_W-1];
    rnd_sat     = rnd_ovf ? (rnd_wide[ACC_W] ? ACC_MIN : ACC_MAX) : rnd_wide[ACC_W-1:0];
    shifted     = $signed(rnd_sat) >>> Q;
    clamp       = !((&shifted[ACC_W-1:N-1]) || !(|shifted[ACC_W-1:N-1]));
    res_clamped = clamp ? (shifted[ACC_W-1] ? RES_MIN : RES_MAX) : shifted[N-1:0];
  end

  // next-state for all stages; everything holds while stalled
  always_comb begin
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    a_valid_d   = a_valid_q;
    a_last_d    = a_last_q;
    a_ovf_d     = a_ovf_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      p_valid_d = in_valid;
      if (in_valid) begin
        p_d       = prod;
        p_first_d = first;
        p_last_d  = last;
      end
      a_valid_d = p_valid_q;
      if (p_valid_q) begin
        acc_d    = sum_sat;
        a_last_d = p_last_q;
        a_ovf_d  = (a_ovf_q && !p_first_q) || sum_ovf;
      end
      // not stalled means any held result is being taken (or none exists)
      out_valid_d = a_valid_q && a_last_q;
      if (a_valid_q && a_last_q) begin
        result_d   = res_clamped;
        overflow_d = a_ovf_q || clamp || rnd_ovf;
      end
    end
  end

  // state registers, asynchronously cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      a_ovf_q     <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      a_valid_q   <= a_valid_d;
      a_last_q    <= a_last_d;
      a_ovf_q     <= a_ovf_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vs_fp_mac_pipe.sv
// Directed bench for vs_fp_mac_pipe: one instance rounds, one truncates.
module tb_vs_fp_mac_pipe;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int ACC_W = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0, first = 1'b0, last = 1'b0, out_ready = 1'b1;
  logic [N-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, overflow;
  logic [N-1:0] result;
  logic         in_ready_t, out_valid_t, overflow_t;
  logic [N-1:0] result_t;

  int checks = 0;
  int errors = 0;
  logic [N:0] q_r[$];
  logic [N:0] q_t[$];

  always #5 clock = ~clock;

  vs_fp_mac_pipe #(.N(N), .Q(Q), .ACC_W(ACC_W), .ROUND(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .first(first), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow));

  vs_fp_mac_pipe #(.N(N), .Q(Q), .ACC_W(ACC_W), .ROUND(0)) dut_t (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(a), .b(b), .first(first), .last(last), .out_valid(out_valid_t),
    .out_ready(out_ready), .result(result_t), .overflow(overflow_t));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // capture every consumed result ({overflow, result}); out_ready only moves after posedge
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready)   q_r.push_back({overflow, result});
      if (out_valid_t && out_ready) q_t.push_back({overflow_t, result_t});
    end
  end

  task automatic beat(input logic [N-1:0] av, input logic [N-1:0] bv, input logic f, input logic l);
    int n;
    a = av; b = bv; first = f; last = l; in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) chk("beat_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clock);
    #1;
  endtask

  // expect exactly one result from each instance, then clear the queues
  task automatic check_one(input string tag, input logic [N:0] exp_r, input logic [N:0] exp_t);
    logic [N:0] gr, gt;
    gr = (q_r.size() > 0) ? q_r[0] : '1;
    gt = (q_t.size() > 0) ? q_t[0] : '1;
    chk({tag, "_count"}, 64'(q_r.size()), 64'd1);
    chk({tag, "_rnd"}, 64'(gr), 64'(exp_r));
    chk({tag, "_trunc"}, 64'(gt), 64'(exp_t));
    q_r.delete();
    q_t.delete();
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // single product with latency check: 1.0 * 2.0 = 2.0
    beat(32'd32768, 32'd65536, 1'b1, 1'b1);
    chk("lat_edge_t", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    chk("lat_edge_t1", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    chk("lat_edge_t2", 64'(out_valid), 64'd1);
    chk("lat_result", 64'(result), 64'd65536);
    drain();
    check_one("single", {1'b0, 32'd65536}, {1'b0, 32'd65536});

    // 4-beat dot product: 1 + 2 - 1 + 0.5 (each times 1.0) = 2.5
    beat(32'd32768, 32'd32768, 1'b1, 1'b0);
    beat(32'd65536, 32'd32768, 1'b0, 1'b0);
    beat(32'hFFFF_8000, 32'd32768, 1'b0, 1'b0);
    beat(32'd16384, 32'd32768, 1'b0, 1'b1);
    drain();
    check_one("dot4", {1'b0, 32'd81920}, {1'b0, 32'd81920});

    // positive and negative saturation
    beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();
    check_one("sat_pos", {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h7FFF_FFFF});
    beat(32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();
    check_one("sat_neg", {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000});

    // rounding: +/- half an LSB
    beat(32'd1, 32'd16384, 1'b1, 1'b1);
    drain();
    check_one("rnd_pos", {1'b0, 32'd1}, {1'b0, 32'd0});
    beat(32'hFFFF_FFFF, 32'd16384, 1'b1, 1'b1);
    drain();
    check_one("rnd_neg", {1'b0, 32'd0}, {1'b0, 32'hFFFF_FFFF});

    // backpressure: 8 one-beat frames, out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int k = 1; k <= 8; k++) beat(N'(k * 32768), 32'd32768, 1'b1, 1'b1);
      end
      begin
        logic [N-1:0] snap;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b0;
        snap = '0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          if (i == 0) snap = result;
          else        chk("stall_hold", 64'(result), 64'(snap));
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(q_r.size()), 64'd8);
    for (int k = 1; k <= 8; k++)
      chk("bp_order", 64'((q_r.size() >= k) ? q_r[k-1] : '1), 64'({1'b0, N'(k * 32768)}));
    q_r.delete();
    q_t.delete();

    // first mid-frame drops the old partial without emitting a result
    beat(32'd32768, 32'd32768, 1'b1, 1'b0);
    beat(32'd32768, 32'd32768, 1'b0, 1'b0);
    beat(32'd32768, 32'd65536, 1'b1, 1'b1);
    drain();
    check_one("restart", {1'b0, 32'd65536}, {1'b0, 32'd65536});

    // last without first continues from acc (2.0): 2.0 + 1.0 = 3.0
    beat(32'd32768, 32'd32768, 1'b0, 1'b1);
    drain();
    check_one("no_first", {1'b0, 32'd98304}, {1'b0, 32'd98304});

    // asynchronous reset mid-frame, then a fresh frame
    beat(32'd65536, 32'd32768, 1'b1, 1'b0);
    beat(32'd65536, 32'd32768, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    beat(32'd32768, 32'd32768, 1'b0, 1'b1);
    drain();
    check_one("post_rst", {1'b0, 32'd32768}, {1'b0, 32'd32768});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
